int_ctrl: RTL and testbench

- Interrupt controller directly upstream of the branch/jump target unit.
- Synchronises and latches three external interrupt sources, arbitrates them by fixed priority, and supports priority nesting.
- Drives int_req and int_num. The control unit turns these into the IRQ target-select op. Vectors: 0→0x3464, 1→0x3500, 2→0x359c.
- Keeps a return-address stack and drives epc for the RET op.

---
 rtl/int_ctrl.sv | 140 ++++++++++++++
 tb/tb_int_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// Interrupt controller: per-source synchroniser lanes, fixed-priority arbitration
// with priority nesting, and a small return-address stack feeding epc.

module int_ctrl_sync #(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE_TRIG   = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic hit
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES:0]   taps;
  logic                   last;
  logic                   dly;

  assign taps = {sync_q, raw};
  assign last = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      dly    <= 1'b0;
    end else begin
      sync_q <= taps[SYNC_STAGES-1:0];
      dly    <= last;
    end
  end

  assign hit = EDGE_TRIG ? (last & ~dly) : last;
endmodule

module int_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE_TRIG   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  irq_in,
  input  logic        int_en,
  input  logic        int_block,
  input  logic        int_ack,
  input  logic [31:0] ret_pc,
  input  logic        eret,
  output logic        int_req,
  output logic [1:0]  int_num,
  output logic [31:0] epc,
  output logic [2:0]  in_service,
  output logic        eret_err
);
  localparam int NUM_SRC = 3;
  localparam int DEPTH   = 3;

  logic [NUM_SRC-1:0]          hit;
  logic [NUM_SRC-1:0]          pending;
  logic [NUM_SRC-1:0]          allow;
  logic [NUM_SRC-1:0]          avail;
  logic [NUM_SRC-1:0]          num_oh;
  logic [NUM_SRC-1:0]          is_low_oh;
  logic [DEPTH-1:0][31:0]      stack;
  logic [1:0]                  depth;
  logic [1:0]                  depth_pop;
  logic [1:0]                  cand;
  logic                        cand_vld;
  logic                        eligible;
  logic                        accept;
  logic                        pop;

  int_ctrl_sync #(.SYNC_STAGES(SYNC_STAGES), .EDGE_TRIG(EDGE_TRIG)) u_sync [NUM_SRC-1:0] (
    .clk (clk),
    .rst (rst),
    .raw (irq_in),
    .hit (hit)
  );

  // A source may only nest if it outranks every source already in service.
  always_comb begin
    logic blocked;
    blocked = 1'b0;
    allow   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (in_service[i]) blocked = 1'b1;
      allow[i] = ~blocked;
    end
  end

  assign avail = pending & allow;

  always_comb begin
    cand     = 2'd3;
    cand_vld = 1'b0;
    for (int i = NUM_SRC-1; i >= 0; i--) begin
      if (avail[i]) begin
        cand     = 2'(i);
        cand_vld = 1'b1;
      end
    end
  end

  assign eligible  = int_en & ~int_block & cand_vld & ~int_ack;
  assign accept    = int_ack & int_req & ~int_block;
  assign pop       = eret & (depth != 2'd0);
  assign num_oh    = 3'b001 << int_num;
  assign is_low_oh = in_service & (~in_service + 3'd1);
  assign depth_pop = pop ? depth - 2'd1 : depth;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending    <= '0;
      in_service <= '0;
      stack      <= '0;
      depth      <= 2'd0;
      int_req    <= 1'b0;
      int_num    <= 2'd3;
      eret_err   <= 1'b0;
    end else begin
      // New set wins over an ack clear landing on the same edge.
      pending    <= (pending & ~(accept ? num_oh : '0)) | hit;
      in_service <= (in_service & ~(pop ? is_low_oh : '0)) | (accept ? num_oh : '0);
      // Pop happens first so eret+ack replaces the top entry in place.
      if (accept && depth_pop != 2'(DEPTH)) begin
        for (int i = 0; i < DEPTH; i++)
          if (depth_pop == 2'(i)) stack[i] <= ret_pc;
        depth <= depth_pop + 2'd1;
      end else begin
        depth <= depth_pop;
      end
      int_req  <= eligible;
      int_num  <= eligible ? cand : 2'd3;
      eret_err <= eret & (depth == 2'd0);
    end
  end

  always_comb begin
    epc = '0;
    for (int i = 0; i < DEPTH; i++)
      if (depth == 2'(i + 1)) epc = stack[i];
  end
endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed scenarios against known values, then random
// traffic checked every cycle against a queue-based reference model.

module tb_int_ctrl;
  localparam int  S    = 2;
  localparam bit  EDGE = 1'b1;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  irq_in;
  logic        int_en, int_block, int_ack, eret;
  logic [31:0] ret_pc;
  logic        int_req;
  logic [1:0]  int_num;
  logic [31:0] epc;
  logic [2:0]  in_service;
  logic        eret_err;

  int checks   = 0;
  int failures = 0;

  int_ctrl #(.SYNC_STAGES(S), .EDGE_TRIG(EDGE)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .int_en(int_en), .int_block(int_block),
    .int_ack(int_ack), .ret_pc(ret_pc), .eret(eret), .int_req(int_req),
    .int_num(int_num), .epc(epc), .in_service(in_service), .eret_err(eret_err)
  );

  always #5 clk = ~clk;

  // reference model state
  logic        m_req, m_err;
  logic [1:0]  m_num;
  logic [2:0]  m_pend, m_is;
  logic [31:0] stk[$];
  logic [2:0]  hist[$];

  function automatic logic [31:0] m_epc();
    return (stk.size() == 0) ? 32'h0 : stk[stk.size()-1];
  endfunction

  task automatic model_reset();
    m_req = 1'b0; m_num = 2'd3; m_pend = 3'b0; m_is = 3'b0; m_err = 1'b0;
    stk.delete(); hist.delete();
    for (int i = 0; i < S + 2; i++) hist.push_back(3'b0);
  endtask

  // One clock edge; the model consumes the inputs as they stood at the edge.
  task automatic step();
    logic       acc, el;
    int         low_is, cnd;
    logic [2:0] np, ni;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      acc = int_ack && m_req && !int_block;
      low_is = 3;
      for (int i = 2; i >= 0; i--) if (m_is[i]) low_is = i;
      cnd = 3;
      for (int i = 2; i >= 0; i--) if (m_pend[i] && i < low_is) cnd = i;
      el = int_en && !int_block && (cnd != 3) && !int_ack;
      hist.push_front(irq_in);
      void'(hist.pop_back());
      np = m_pend;
      if (acc) np[m_num] = 1'b0;
      for (int i = 0; i < 3; i++)
        if (EDGE ? (hist[S][i] && !hist[S+1][i]) : hist[S][i]) np[i] = 1'b1;
      ni = m_is;
      m_err = eret && (stk.size() == 0);
      if (eret && stk.size() > 0) begin
        void'(stk.pop_back());
        if (low_is < 3) ni[low_is] = 1'b0;
      end
      if (acc) begin
        ni[m_num] = 1'b1;
        if (stk.size() < 3) stk.push_back(ret_pc);
      end
      m_req  = el;
      m_num  = el ? 2'(cnd) : 2'd3;
      m_pend = np;
      m_is   = ni;
    end
    #1;
  endtask

  task automatic pulse(input logic [2:0] b);
    irq_in = irq_in | b; step(); irq_in = irq_in & ~b;
  endtask

  task automatic ack(input logic [31:0] pc);
    int_ack = 1'b1; ret_pc = pc; step(); int_ack = 1'b0;
  endtask

  task automatic do_eret();
    eret = 1'b1; step(); eret = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); step();
    checks++; if (int_req !== 1'b0)     begin failures++; $display("FAIL reset_req act=%0b exp=0", int_req); end
    checks++; if (int_num !== 2'd3)     begin failures++; $display("FAIL reset_num act=%0d exp=3", int_num); end
    checks++; if (epc !== 32'h0)        begin failures++; $display("FAIL reset_epc act=%h exp=0", epc); end
    checks++; if (in_service !== 3'b0)  begin failures++; $display("FAIL reset_is act=%b exp=000", in_service); end
    checks++; if (eret_err !== 1'b0)    begin failures++; $display("FAIL reset_err act=%0b exp=0", eret_err); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    pulse(3'b010); step(); step();
    checks++; if (int_req !== 1'b0) begin failures++; $display("FAIL single_early act=%0b exp=0", int_req); end
    step();
    checks++; if (int_req !== 1'b1 || int_num !== 2'd1)
      begin failures++; $display("FAIL single_req act=%0b/%0d exp=1/1", int_req, int_num); end
    ack(32'h1004);
    checks++; if (int_req !== 1'b0 || in_service !== 3'b010 || epc !== 32'h1004)
      begin failures++; $display("FAIL single_ack act=%0b/%b/%h exp=0/010/1004", int_req, in_service, epc); end
    do_eret();
    checks++; if (in_service !== 3'b000 || epc !== 32'h0)
      begin failures++; $display("FAIL single_eret act=%b/%h exp=000/0", in_service, epc); end
    step();
    checks++; if (int_req !== 1'b0) begin failures++; $display("FAIL single_idle act=%0b exp=0", int_req); end
  endtask

  task automatic test_nesting();
    pulse(3'b110); step(); step(); step();
    checks++; if (int_req !== 1'b1 || int_num !== 2'd1)
      begin failures++; $display("FAIL nest_pri act=%0b/%0d exp=1/1", int_req, int_num); end
    ack(32'h2000);
    pulse(3'b001); step(); step(); step();
    checks++; if (int_req !== 1'b1 || int_num !== 2'd0)
      begin failures++; $display("FAIL nest_irq0 act=%0b/%0d exp=1/0", int_req, int_num); end
    ack(32'h3500);
    checks++; if (epc !== 32'h3500 || in_service !== 3'b011)
      begin failures++; $display("FAIL nest_push act=%h/%b exp=3500/011", epc, in_service); end
    do_eret();
    checks++; if (epc !== 32'h2000 || in_service !== 3'b010)
      begin failures++; $display("FAIL nest_pop act=%h/%b exp=2000/010", epc, in_service); end
    do_eret(); step();
    checks++; if (int_req !== 1'b1 || int_num !== 2'd2)
      begin failures++; $display("FAIL nest_rereq act=%0b/%0d exp=1/2", int_req, int_num); end
    ack(32'h40); do_eret(); step();
  endtask

  task automatic test_block();
    int_block = 1'b1;
    pulse(3'b001); step(); step(); step(); step();
    checks++; if (int_req !== 1'b0) begin failures++; $display("FAIL block_req act=%0b exp=0", int_req); end
    int_ack = 1'b1; ret_pc = 32'hdead; step(); int_ack = 1'b0;
    checks++; if (in_service !== 3'b000 || epc !== 32'h0)
      begin failures++; $display("FAIL block_ack act=%b/%h exp=000/0", in_service, epc); end
    int_block = 1'b0; step();
    checks++; if (int_req !== 1'b1 || int_num !== 2'd0)
      begin failures++; $display("FAIL block_release act=%0b/%0d exp=1/0", int_req, int_num); end
    int_en = 1'b0; step();
    checks++; if (int_req !== 1'b0) begin failures++; $display("FAIL en_off act=%0b exp=0", int_req); end
    int_en = 1'b1; step();
    checks++; if (int_req !== 1'b1 || int_num !== 2'd0)
      begin failures++; $display("FAIL en_on act=%0b/%0d exp=1/0", int_req, int_num); end
    ack(32'h50); do_eret(); step();
  endtask

  task automatic test_no_lower();
    pulse(3'b001); step(); step(); step();
    ack(32'h60);
    checks++; if (in_service !== 3'b001) begin failures++; $display("FAIL nolow_is act=%b exp=001", in_service); end
    pulse(3'b100); for (int i = 0; i < 5; i++) step();
    checks++; if (int_req !== 1'b0) begin failures++; $display("FAIL nolow_req act=%0b exp=0", int_req); end
    do_eret();
    checks++; if (int_req !== 1'b0 || in_service !== 3'b000)
      begin failures++; $display("FAIL nolow_eret act=%0b/%b exp=0/000", int_req, in_service); end
    step();
    checks++; if (int_req !== 1'b1 || int_num !== 2'd2)
      begin failures++; $display("FAIL nolow_after act=%0b/%0d exp=1/2", int_req, int_num); end
    ack(32'h70); do_eret(); step();
  endtask

  task automatic test_eret_empty();
    do_eret();
    checks++; if (eret_err !== 1'b1 || in_service !== 3'b0 || epc !== 32'h0 || int_req !== 1'b0)
      begin failures++; $display("FAIL eret_empty act=%0b/%b/%h/%0b exp=1/000/0/0", eret_err, in_service, epc, int_req); end
    step();
    checks++; if (eret_err !== 1'b0) begin failures++; $display("FAIL eret_err_pulse act=%0b exp=0", eret_err); end
  endtask

  task automatic test_eret_ack();
    pulse(3'b010); step(); step(); step();
    ack(32'h1111);
    pulse(3'b001); step(); step(); step();
    checks++; if (int_req !== 1'b1 || int_num !== 2'd0)
      begin failures++; $display("FAIL ea_req act=%0b/%0d exp=1/0", int_req, int_num); end
    int_ack = 1'b1; eret = 1'b1; ret_pc = 32'h2222; step(); int_ack = 1'b0; eret = 1'b0;
    checks++; if (epc !== 32'h2222 || in_service !== 3'b001)
      begin failures++; $display("FAIL ea_swap act=%h/%b exp=2222/001", epc, in_service); end
    do_eret();
    checks++; if (epc !== 32'h0 || in_service !== 3'b000 || eret_err !== 1'b0)
      begin failures++; $display("FAIL ea_depth1 act=%h/%b/%0b exp=0/000/0", epc, in_service, eret_err); end
    do_eret();
    checks++; if (eret_err !== 1'b1) begin failures++; $display("FAIL ea_empty act=%0b exp=1", eret_err); end
    step();
  endtask

  task automatic test_edge_in_ack();
    pulse(3'b010); step(); step(); step();
    irq_in[1] = 1'b1; step(); irq_in[1] = 1'b0; step();
    ack(32'h80);
    checks++; if (in_service !== 3'b010 || int_req !== 1'b0)
      begin failures++; $display("FAIL eia_ack act=%b/%0b exp=010/0", in_service, int_req); end
    do_eret(); step();
    checks++; if (int_req !== 1'b1 || int_num !== 2'd1)
      begin failures++; $display("FAIL eia_pending act=%0b/%0d exp=1/1", int_req, int_num); end
    ack(32'h90); do_eret(); step();
  endtask

  task automatic test_async_reset();
    pulse(3'b010); step(); step(); step(); ack(32'hA0);
    pulse(3'b001); step(); step(); step(); ack(32'hB0);
    checks++; if (epc !== 32'hB0 || in_service !== 3'b011)
      begin failures++; $display("FAIL ar_setup act=%h/%b exp=b0/011", epc, in_service); end
    irq_in = 3'b100;
    #2 rst = 1'b1; model_reset();
    #1;
    checks++; if (int_req !== 1'b0 || int_num !== 2'd3 || epc !== 32'h0 || in_service !== 3'b0 || eret_err !== 1'b0)
      begin failures++; $display("FAIL ar_async act=%0b/%0d/%h/%b/%0b exp=0/3/0/000/0", int_req, int_num, epc, in_service, eret_err); end
    step(); step();
    rst = 1'b0; irq_in = 3'b000;
    for (int i = 0; i < 5; i++) step();
    checks++; if (int_req !== 1'b0 || in_service !== 3'b0 || epc !== 32'h0)
      begin failures++; $display("FAIL ar_lost act=%0b/%b/%h exp=0/000/0", int_req, in_service, epc); end
  endtask

  task automatic test_random();
    int nfail;
    nfail = 0;
    for (int n = 0; n < 3000 && nfail < 40; n++) begin
      for (int b = 0; b < 3; b++) if ($urandom % 8 == 0) irq_in[b] = ~irq_in[b];
      int_en    = ($urandom % 16) != 0;
      int_block = ($urandom % 5) == 0;
      int_ack   = m_req && ($urandom % 2 == 0);
      ret_pc    = $urandom;
      eret      = ($urandom % 12) == 0;
      step();
      int_ack = 1'b0; eret = 1'b0;
      checks++;
      if (int_req !== m_req || int_num !== m_num || in_service !== m_is ||
          epc !== m_epc() || eret_err !== m_err) begin
        failures++; nfail++;
        $display("FAIL rand cyc=%0d act=%0b/%0d/%b/%h/%0b exp=%0b/%0d/%b/%h/%0b", n,
                 int_req, int_num, in_service, epc, eret_err, m_req, m_num, m_is, m_epc(), m_err);
      end
    end
  endtask

  initial begin
    rst = 1'b1; irq_in = 3'b0; int_en = 1'b1; int_block = 1'b0;
    int_ack = 1'b0; eret = 1'b0; ret_pc = 32'h0;
    model_reset();
    test_reset();
    test_single();
    test_nesting();
    test_block();
    test_no_lower();
    test_eret_empty();
    test_eret_ack();
    test_edge_in_ack();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
